// File: rtl/nes_loader_pkg.sv
// Shared loader definitions: address/data widths, CHR base and the write payload.
package nes_loader_pkg;

  localparam int unsigned LOADER_ADDR_W = 22;
  localparam int unsigned LOADER_DATA_W = 8;

  localparam logic [LOADER_ADDR_W-1:0] CHR_BASE = 22'h200000;

  typedef struct packed {
    logic [LOADER_ADDR_W-1:0] addr;
    logic [LOADER_DATA_W-1:0] data;
  } loader_wr_t;

endpackage

// File: rtl/loader_write_buffer_if.sv
// Loader-side capture and SDRAM-side replay signals of the loader write buffer.
interface loader_write_buffer_if #(
  parameter int unsigned ADDR_W = 22,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8
);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic              slot;
  logic              in_write;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              wait_req;
  logic              drained;
  logic              overflow;
  logic [LVL_W-1:0]  level;

  modport master (
    output slot, in_write, in_addr, in_data,
    input  mem_write, mem_addr, mem_data, wait_req, drained, overflow, level
  );

  modport slave (
    input  slot, in_write, in_addr, in_data,
    output mem_write, mem_addr, mem_data, wait_req, drained, overflow, level
  );
endinterface

// File: rtl/loader_fifo.sv
// Single-clock FIFO of loader writes; explicit level counter, no read bypass.
module loader_fifo
  import nes_loader_pkg::*;
#(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  loader_wr_t       wdata,
  output loader_wr_t       rdata,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  loader_wr_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/loader_write_buffer.sv
// Buffers loader byte writes and replays them to SDRAM one per NES memory slot.
module loader_write_buffer
  import nes_loader_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned ADDR_W      = LOADER_ADDR_W,
  parameter int unsigned DATA_W      = LOADER_DATA_W,
  parameter int unsigned WAIT_MARGIN = 2
) (
  input logic                  clk,
  input logic                  reset,
  loader_write_buffer_if.slave bus
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  typedef enum logic {IDLE, ISSUE} issue_state_t;

  issue_state_t     state;
  loader_wr_t       wr_in;
  loader_wr_t       head;
  logic [LVL_W-1:0] fifo_level;
  logic [LVL_W-1:0] next_level;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push_ok;
  logic             pop_ok;

  assign wr_in.addr = LOADER_ADDR_W'(bus.in_addr);
  assign wr_in.data = LOADER_DATA_W'(bus.in_data);

  loader_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.in_write),
    .pop   (bus.slot),
    .wdata (wr_in),
    .rdata (head),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Fullness is taken from the registered level, so a push at DEPTH drops even alongside a pop.
  assign push_ok    = bus.in_write && !fifo_full;
  assign pop_ok     = bus.slot && !fifo_empty;
  assign next_level = fifo_level + LVL_W'(push_ok) - LVL_W'(pop_ok);

  // Write port holds its request for a whole slot period; it only changes on slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      bus.mem_addr <= '0;
      bus.mem_data <= '0;
      bus.wait_req <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      if (bus.slot) begin
        if (!fifo_empty) begin
          state        <= ISSUE;
          bus.mem_addr <= ADDR_W'(head.addr);
          bus.mem_data <= DATA_W'(head.data);
        end else begin
          state <= IDLE;
        end
      end
      if (bus.in_write && fifo_full) bus.overflow <= 1'b1;
      bus.wait_req <= (next_level >= LVL_W'(DEPTH - WAIT_MARGIN));
    end
  end

  assign bus.mem_write = (state == ISSUE);
  assign bus.level     = fifo_level;
  assign bus.drained   = fifo_empty && (state == IDLE);

endmodule
